// File: rtl/bowling_pkg.sv
// Shared types and turn-rule helper for the bowling turn scheduler.
// Frame/throw/pin widths and the per-throw advance function.
package bowling_pkg;

  localparam int PIN_W   = 4;
  localparam int FRAME_W = 4;
  localparam int THROW_W = 2;

  localparam logic [PIN_W-1:0]   MAX_PINS   = 4'd10;
  localparam logic [FRAME_W-1:0] LAST_FRAME = 4'd10;

  typedef enum logic [1:0] {
    S_WAIT,
    S_ISSUE,
    S_ADV,
    S_OVER
  } state_t;

  typedef struct packed {
    logic [THROW_W-1:0] throw_idx;
    logic [PIN_W-1:0]   pins;
    logic               strike0;
    logic               end_turn;
  } turn_t;

  // n never exceeds pins here, so rem cannot underflow
  function automatic turn_t turn_rule(
    input logic [FRAME_W-1:0] frame,
    input logic [THROW_W-1:0] idx,
    input logic [PIN_W-1:0]   pins,
    input logic [PIN_W-1:0]   n,
    input logic               strike0
  );
    logic [PIN_W-1:0] rem;
    logic             clear;
    logic             last;
    turn_t            t;
    rem         = pins - n;
    clear       = (rem == '0);
    last        = (frame == LAST_FRAME);
    t.throw_idx = idx;
    t.pins      = pins;
    t.strike0   = strike0;
    t.end_turn  = 1'b0;
    unique case (1'b1)
      (!last): begin
        if (idx == 2'd0 && !clear) begin
          t.throw_idx = 2'd1;
          t.pins      = rem;
        end else begin
          t.end_turn = 1'b1;
        end
      end
      (last && idx == 2'd0): begin
        t.throw_idx = 2'd1;
        t.pins      = clear ? MAX_PINS : rem;
        t.strike0   = clear;
      end
      (last && idx == 2'd1 && (strike0 || clear)): begin
        t.throw_idx = 2'd2;
        t.pins      = clear ? MAX_PINS : rem;
      end
      default: t.end_turn = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bowling_turn_scheduler_if.sv
// Operator/keeper bundle of the bowling turn scheduler.
// master = operator side, slave = scheduler side.
interface bowling_turn_scheduler_if #(
  parameter int NUM_PLAYERS = 4
);
  logic [3:0]             N;
  logic                   UPD;
  logic [NUM_PLAYERS-1:0] upd_out;
  logic [3:0]             n_out;
  logic [2:0]             player;
  logic [3:0]             frame;
  logic [1:0]             throw_idx;
  logic [3:0]             pins_standing;
  logic                   reject;
  logic                   game_over;

  modport master (
    output N, UPD,
    input  upd_out, n_out, player, frame,
    input  throw_idx, pins_standing,
    input  reject, game_over
  );

  modport slave (
    input  N, UPD,
    output upd_out, n_out, player, frame,
    output throw_idx, pins_standing,
    output reject, game_over
  );
endinterface

// File: rtl/bowling_upd_conditioner.sv
// UPD button conditioner: 2-flop sync and rising-edge detect.
// BOWLING_UPD_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability filter.
module bowling_upd_conditioner
`ifdef BOWLING_UPD_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic upd,
  output logic upd_evt
);

  // Sync resets high so a button held through reset is not an event
  logic s1, s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= upd;
      s2 <= s1;
    end
  end

`ifdef BOWLING_UPD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          lvl, lvl_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      lvl   <= 1'b1;
      lvl_q <= 1'b1;
    end else begin
      lvl_q <= lvl;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign upd_evt = lvl & ~lvl_q;
`else
  logic s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) s3 <= 1'b1;
    else       s3 <= s2;
  end

  assign upd_evt = s2 & ~s3;
`endif

endmodule

// File: rtl/bowling_turn_scheduler.sv
// Bowling turn scheduler: validates throws, strobes keepers, tracks turns.
// Optional UPD debounce via BOWLING_UPD_DEBOUNCE_EN.
module bowling_turn_scheduler
  import bowling_pkg::*;
#(
  parameter int NUM_PLAYERS     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                      clock,
  input logic                      reset,
  bowling_turn_scheduler_if.slave  bus
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("bowling_turn_scheduler: bad parameter");
  end

  state_t                 state_q, state_d;
  logic [3:0]             n_out_q, n_out_d;
  logic [3:0]             pins_q, pins_d;
  logic [3:0]             frame_q, frame_d;
  logic [3:0]             pend_n_q, pend_n_d;
  logic [2:0]             player_q, player_d;
  logic [1:0]             idx_q, idx_d;
  logic                   strike0_q, strike0_d;
  logic                   pend_q, pend_d;
  logic                   reject_q, reject_d;
  logic [NUM_PLAYERS-1:0] upd_q, upd_d;

  logic       upd_evt;
  logic [3:0] evt_n;
  turn_t      turn;

  bowling_upd_conditioner
`ifdef BOWLING_UPD_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_cond (
      .clock   (clock),
      .reset   (reset),
      .upd     (bus.UPD),
      .upd_evt (upd_evt)
    );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      n_out_q   <= '0;
      pins_q    <= MAX_PINS;
      frame_q   <= 4'd1;
      pend_n_q  <= '0;
      player_q  <= '0;
      idx_q     <= '0;
      strike0_q <= 1'b0;
      pend_q    <= 1'b0;
      reject_q  <= 1'b0;
      upd_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_out_q   <= n_out_d;
      pins_q    <= pins_d;
      frame_q   <= frame_d;
      pend_n_q  <= pend_n_d;
      player_q  <= player_d;
      idx_q     <= idx_d;
      strike0_q <= strike0_d;
      pend_q    <= pend_d;
      reject_q  <= reject_d;
      upd_q     <= upd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_out_d   = n_out_q;
    pins_d    = pins_q;
    frame_d   = frame_q;
    pend_n_d  = pend_n_q;
    player_d  = player_q;
    idx_d     = idx_q;
    strike0_d = strike0_q;
    pend_d    = pend_q;
    reject_d  = 1'b0;
    upd_d     = '0;
    evt_n     = pend_q ? pend_n_q : bus.N;
    turn      = turn_rule(frame_q, idx_q, pins_q,
                          n_out_q, strike0_q);

    // While busy, park one event; later ones are dropped
    if (state_q != S_WAIT && upd_evt && !pend_q) begin
      pend_d   = 1'b1;
      pend_n_d = bus.N;
    end

    unique case (state_q)
      S_WAIT: begin
        if (pend_q || upd_evt) begin
          if (pend_q) begin
            pend_d   = upd_evt;
            pend_n_d = bus.N;
          end
          if (evt_n <= pins_q) begin
            n_out_d = evt_n;
            state_d = S_ISSUE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        upd_d   = NUM_PLAYERS'(1) << player_q;
        state_d = S_ADV;
      end
      S_ADV: begin
        idx_d     = turn.throw_idx;
        pins_d    = turn.pins;
        strike0_d = turn.strike0;
        state_d   = S_WAIT;
        if (turn.end_turn) begin
          idx_d  = '0;
          pins_d = MAX_PINS;
          if (player_q == 3'(NUM_PLAYERS - 1)) begin
            player_d = '0;
            if (frame_q == LAST_FRAME) begin
              state_d = S_OVER;
              pend_d  = 1'b0;
            end else begin
              frame_d = frame_q + 4'd1;
            end
          end else begin
            player_d = player_q + 3'd1;
          end
        end
      end
      S_OVER: pend_d = 1'b0;
      default: state_d = S_WAIT;
    endcase
  end

  assign bus.upd_out       = upd_q;
  assign bus.n_out         = n_out_q;
  assign bus.player        = player_q;
  assign bus.frame         = frame_q;
  assign bus.throw_idx     = idx_q;
  assign bus.pins_standing = pins_q;
  assign bus.reject        = reject_q;
  assign bus.game_over     = (state_q == S_OVER);

endmodule
